// File: rtl/freq_divider_pkg.sv
// Shared widths and divisor limits for the programmable clock divider.
package freq_divider_pkg;
  localparam int unsigned FREQ_DIV_WIDTH = 32;
  localparam int unsigned FREQ_DIV_MIN   = 2;
  localparam int unsigned FREQ_DIV_RESET = 2;
endpackage

// File: rtl/freq_div_counter.sv
// Modulo counter with clear/enable; wraps to 0 once cnt_q reaches or passes last.
// One cycle per count, no backpressure; clear has priority over enable.
module freq_div_counter
  import freq_divider_pkg::*;
#(
  parameter int WIDTH = FREQ_DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] cnt_next,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    // >= rather than == so an out-of-range count can never run away.
    wrap     = (cnt_q >= last);
    cnt_next = wrap ? '0 : cnt_q + WIDTH'(1);
    cnt_d    = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/freq_divider.sv
// Integer clock divider: registered ClkOutput, low floor(N/2) then high N-floor(N/2) cycles.
// Optional one-cycle wrap pulse Tick when FREQ_DIV_TICK_EN is defined; no backpressure.
module freq_divider
  import freq_divider_pkg::*;
#(
  parameter int WIDTH = FREQ_DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             ConfigDiv,
  input  logic             Enable,
`ifdef FREQ_DIV_TICK_EN
  output logic             Tick,
`endif
  output logic             ClkOutput
);

  logic [WIDTH-1:0] div_q, div_d;
  logic             out_q, out_d;
  logic [WIDTH-1:0] n_eff;
  logic [WIDTH-1:0] n_last;
  logic [WIDTH-1:0] low_len;
  logic [WIDTH-1:0] cnt_next;
  logic             wrap;
  logic             clr;
  logic             run;

  always_comb begin
    // Divisors 0 and 1 are clamped so the counter always has a real period.
    n_eff   = (div_q >= WIDTH'(FREQ_DIV_MIN)) ? div_q : WIDTH'(FREQ_DIV_MIN);
    n_last  = n_eff - WIDTH'(1);
    low_len = n_eff >> 1;
    clr     = ConfigDiv | ~Enable;
    run     = ~ConfigDiv & Enable;
    div_d   = ConfigDiv ? Din : div_q;
    out_d   = run & (cnt_next >= low_len);
  end

  freq_div_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (Clk),
    .reset    (Reset),
    .clr      (clr),
    .en       (Enable),
    .last     (n_last),
    .cnt_next (cnt_next),
    .wrap     (wrap)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q <= WIDTH'(FREQ_DIV_RESET);
      out_q <= 1'b0;
    end else begin
      div_q <= div_d;
      out_q <= out_d;
    end
  end

  assign ClkOutput = out_q;

`ifdef FREQ_DIV_TICK_EN
  logic tick_q, tick_d;

  always_comb begin
    tick_d = run & wrap;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign Tick = tick_q;
`else
  logic unused_wrap;
  assign unused_wrap = wrap;
`endif

endmodule

// File: tb/tb_freq_divider.sv
// Bench for freq_divider: directed scenarios then random traffic against a phase-arithmetic model.
module tb_freq_divider;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        cfg;
  logic        en;
  logic        clk_out;
  logic        tick;

  int n_vec;
  int n_err;

  // Model state: stored divisor and enabled edges since the last restart.
  longint unsigned m_div;
  longint unsigned m_edges;

  freq_divider #(.WIDTH(32)) dut (
    .Clk       (clk),
    .Reset     (rst),
    .Din       (din),
    .ConfigDiv (cfg),
    .Enable    (en),
`ifdef FREQ_DIV_TICK_EN
    .Tick      (tick),
`endif
    .ClkOutput (clk_out)
  );

`ifndef FREQ_DIV_TICK_EN
  assign tick = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic [31:0] d, input logic e);
    longint unsigned n;
    longint unsigned ph;
    logic exp_out;
    logic exp_tick;
    @(negedge clk);
    rst = r; cfg = c; din = d; en = e;
    @(posedge clk);
    if (r) begin
      m_div = 2; m_edges = 0;
    end else if (c) begin
      m_div = longint'(d); m_edges = 0;
    end else if (!e) begin
      m_edges = 0;
    end else begin
      m_edges++;
    end
    n        = (m_div < 2) ? 2 : m_div;
    ph       = m_edges % n;
    exp_out  = (m_edges != 0) && (ph >= n / 2);
    exp_tick = (m_edges != 0) && (ph == 0);
    #1;
    chk("clk_out", {31'd0, clk_out}, {31'd0, exp_out});
`ifdef FREQ_DIV_TICK_EN
    chk("tick", {31'd0, tick}, {31'd0, exp_tick});
`endif
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_div = 2; m_edges = 0;
    rst = 1'b1; cfg = 1'b0; din = '0; en = 1'b0;

    drive(1, 0, 0, 0);
    drive(1, 0, 0, 1);
    chk("reset_out", {31'd0, clk_out}, 32'd0);
    chk("reset_tick", {31'd0, tick}, 32'd0);

    // Default divisor 2 after reset.
    repeat (8) drive(0, 0, 0, 1);
    // Load 5 while disabled, then run.
    drive(0, 0, 0, 0);
    drive(0, 1, 5, 0);
    repeat (15) drive(0, 0, 0, 1);
    // Load 4 with enable held: the load wins that edge.
    drive(0, 1, 4, 1);
    repeat (12) drive(0, 0, 0, 1);
    // Clamp cases.
    drive(0, 1, 0, 0);
    repeat (6) drive(0, 0, 0, 1);
    drive(0, 1, 1, 1);
    repeat (6) drive(0, 0, 0, 1);
    // N=6: drop enable mid-high, then re-enable.
    drive(0, 1, 6, 0);
    repeat (10) drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    repeat (14) drive(0, 0, 0, 1);
    // Reset mid-period with N=5.
    drive(0, 1, 5, 1);
    repeat (3) drive(0, 0, 0, 1);
    drive(1, 0, 0, 1);
    repeat (8) drive(0, 0, 0, 1);

    for (int i = 0; i < 2000; i++) begin
      logic        r, c, e;
      logic [31:0] d;
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 11) != 0);
      d = ($urandom_range(0, 49) == 0) ? $urandom : 32'($urandom_range(0, 12));
      drive(r, c, d, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/freq_divider.md
# freq_divider

Programmable integer clock divider. Divides the system clock `Clk` by a runtime-configured 32-bit divisor N. It produces a registered, glitch-free divided clock `ClkOutput`, synchronous to `Clk`. It sits beside a register or config interface that loads N through `Din`/`ConfigDiv`; `Enable` gates the output.

## Interface
Parameters:
- `WIDTH`, default 32: width of `Din`, the divisor register and the counter.

Ports:
- `Clk`  in  1  system clock. All logic is on the rising edge.
- `Reset`  in  1  reset, synchronous and active-high.
- `Din`  in  WIDTH  divisor value. Sampled only when `ConfigDiv`=1.
- `ConfigDiv`  in  1  load strobe. When 1 at a clock edge, `Din` is written into the divisor register.
- `Enable`  in  1  1 = run the divider; 0 = counter cleared and output held low.
- `ClkOutput`  out  1  divided clock, registered.
- `Tick`  out  1  one-cycle wrap pulse. Present only with `FREQ_DIV_TICK_EN`.

## Operation
- State:
  - `div_q` (WIDTH): divisor register.
  - `cnt_q` (WIDTH): modulo counter.
  - `out_q`: drives `ClkOutput`.
- Effective divisor N = `div_q` if `div_q` ≥ 2, else 2. Values 0 and 1 are clamped to 2, so they never stall the divider or produce a combinational clock.
- Low-phase length L = floor(N/2). High-phase length = N − L (the extra cycle goes to the high phase when N is odd).
- Priority at each rising edge, highest first:
  1. `Reset`: `div_q`←2, `cnt_q`←0, `out_q`←0.
  2. `ConfigDiv`=1: `div_q`←`Din`, `cnt_q`←0, `out_q`←0. This applies regardless of `Enable`; the new divisor starts from phase 0.
  3. `Enable`=0: `cnt_q`←0, `out_q`←0. `div_q` is retained.
  4. `Enable`=1:
     - cnt_next = (`cnt_q` == N−1) ? 0 : `cnt_q`+1.
     - `cnt_q`←cnt_next.
     - `out_q`←(cnt_next ≥ L).
- The counter compares with ≥ N−1, not ==. If `cnt_q` ever exceeds N−1, it wraps to 0 on the next enabled edge.
- All comparisons are unsigned, WIDTH bits. N−1 never underflows because N ≥ 2.

## Timing
- Reset values: `ClkOutput`=0, `Tick`=0, `div_q`=2.
- `ClkOutput` is a flop output with no combinational path from any input.
- Enable latency: `Enable` is sampled 1 at edge k. With N=2, `ClkOutput` rises after edge k. With N>2, the first rise follows edge k+L−1.
- Steady state while enabled:
  - Period is exactly N `Clk` cycles.
  - Low for L cycles, high for N−L cycles.
  - The phase is the same on every period.
- `Enable` deasserted: `ClkOutput` goes 0 after the same edge. Re-enabling restarts from phase 0.
- `ConfigDiv` together with `Enable`=1: the load wins for that edge. Counting resumes with the new N on the next edge.
- Reset in the middle of a period: the period is aborted and the divisor returns to 2.

## Configuration
- `FREQ_DIV_TICK_EN` defined:
  - Adds output `Tick`, registered.
  - `Tick`=1 for exactly one cycle after each enabled edge where `cnt_q` wraps N−1→0.
  - `Tick` is 0 under Reset, ConfigDiv, or `Enable`=0.
- Not defined: the `Tick` port and its logic are absent.
- Behaviour of `ClkOutput` is identical in both builds.

## Structure
- Package `freq_divider_pkg`:
  - `FREQ_DIV_WIDTH`=32.
  - `FREQ_DIV_MIN`=2 (clamp floor).
  - `FREQ_DIV_RESET`=2 (reset divisor).
- One sub-module is natural: `freq_div_counter`. It is a modulo-N counter with clear and enable, outputs `cnt_next` and a wrap flag, and is reused for `Tick`.
- The top level holds `div_q`, the clamp and the phase compare.

## Test plan
- Reset 23 ns (10 ns clock), then `Enable`=1 with no config → divisor defaults to 2; `ClkOutput` toggles every cycle, period 20 ns.
- `Enable`=0, `ConfigDiv`=1, `Din`=5 for one cycle, then `Enable`=1 → `ClkOutput` low 2 cycles and high 3 cycles repeatedly, period 50 ns.
- `Din`=4 loaded, enabled → low 2 and high 2; `Tick` (macro on) pulses once every 4 cycles, coincident with the falling edge of `ClkOutput`.
- `Din`=0, then `Din`=1, each loaded and enabled → both behave as N=2; no stall, no X.
- `Enable` dropped mid-high-phase with N=6 → `ClkOutput`=0 after the next edge. Re-enable → first rise after 2 edges (L−1=2), then period 6.
- `Reset` asserted mid-period with N=5 → `ClkOutput`=0 after the edge. With `Enable` held high after release, the output divides by 2.
